cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low.
REQ-004 address  in  32  byte address of the pipeline memory access.
REQ-005 wdata  in  32  pipeline store data.
REQ-006 MEM_R_EN  in  1  pipeline load request, held until ready.
REQ-007 MEM_W_EN  in  1  pipeline store request, held until ready.
REQ-008 rdata  out  32  load result, valid only while ready=1 for a load.
REQ-009 ready  out  1  access complete this cycle; pipeline freezes while low.
REQ-010 cache_address  out  19  set-associative cache address (tag [18:9], index [8:3], word select [2]).
REQ-011 cache_wdata  out  32  word to write into the cache.
REQ-012 cache_w_en  out  1  cache word-write strobe.
REQ-013 invalidate  out  1  invalidate the hitting way of the addressed set.
REQ-014 change_LRU  out  1  toggle the set's LRU bit with this write.
REQ-015 hit_or_miss  in  1  cache hit for cache_address.
REQ-016 cache_rdata  in  32  cache read word for cache_address.
REQ-017 sram_address  out  32  SRAM byte address.
REQ-018 sram_wdata  out  32  SRAM store data.
REQ-019 sram_read  out  1  SRAM block-read request, held until sram_ready.
REQ-020 sram_write  out  1  SRAM word-write request, held until sram_ready.
REQ-021 sram_rdata  in  64  SRAM block; [31:0] is word 0, [63:32] is word 1.
REQ-022 sram_ready  in  1  one-cycle SRAM completion pulse.

Function
REQ-023 Address mapping SHALL be fixed: cache_address = address[18:0] in IDLE, WRITE_SRAM and READ_SRAM.
REQ-024 In FILL_LO, cache_address SHALL be {address[18:3], 1'b0, address[1:0]}; in FILL_HI, it SHALL be {address[18:3], 1'b1, address[1:0]}.
REQ-025 SRAM mapping SHALL be fixed: sram_address = {address[31:3], 3'b000} for reads and address for writes; sram_wdata = wdata.
REQ-026 The FSM SHALL have the states IDLE, READ_SRAM, FILL_LO, FILL_HI and WRITE_SRAM.
REQ-027 All SRAM and cache strobes SHALL be decoded from state and inputs only.
REQ-028 IDLE, load hit (MEM_R_EN=1, MEM_W_EN=0, hit_or_miss=1): ready=1 and rdata=cache_rdata in the same cycle (zero-wait); stay in IDLE.
REQ-029 IDLE, load miss: ready=0; next state READ_SRAM.
REQ-030 IDLE, store (MEM_W_EN=1; stores take priority over loads): invalidate=hit_or_miss; ready=0; next state WRITE_SRAM. Write-through, no-allocate.
REQ-031 IDLE, no request: ready=1; all strobes=0.
REQ-032 READ_SRAM: sram_read=1. On sram_ready=1, latch sram_rdata into a 64-bit block register and go to FILL_LO.
REQ-033 FILL_LO: cache_w_en=1, cache_wdata=block[31:0], change_LRU=0; go to FILL_HI.
REQ-034 FILL_HI: cache_w_en=1, cache_wdata=block[63:32], change_LRU=1, ready=1; rdata = address[2] ? block[63:32] : block[31:0]; go to IDLE.
REQ-035 WRITE_SRAM: sram_write=1. On sram_ready=1, ready=1 and go to IDLE.
REQ-036 sram_read and sram_write SHALL never be high together; cache_w_en and invalidate SHALL never be high together.
REQ-037 A request that changes or drops while ready=0 SHALL be ignored until return to IDLE. The latched address and data SHALL be used for the rest of the transaction.
REQ-038 sram_ready while in IDLE, FILL_LO or FILL_HI SHALL be ignored.

Reset
REQ-039 rst=0 SHALL immediately force IDLE, clear the block register, and drive sram_read, sram_write, cache_w_en, invalidate and change_LRU to 0, including mid-transaction.
REQ-040 After reset is released, ready SHALL follow the IDLE rules.

Verification
REQ-041 Load hit: address=0x0000_0104, hit_or_miss=1, cache_rdata=0xDEADBEEF -> same-cycle ready=1, rdata=0xDEADBEEF, no SRAM strobe.
REQ-042 Load miss: address=0x0000_0104, hit=0, sram_ready after 4 cycles with sram_rdata=0x11111111_22222222 -> sram_address=0x100; FILL_LO writes 0x22222222 with change_LRU=0; FILL_HI writes 0x11111111 with change_LRU=1; ready=1, rdata=0x11111111; 7 cycles total.
REQ-043 Store hit: address=0x0000_0200, wdata=0xA5A5A5A5, hit=1 -> invalidate=1 for one cycle; sram_write held with sram_address=0x200 until sram_ready; ready=1 that cycle.
REQ-044 Simultaneous MEM_R_EN=MEM_W_EN=1 -> store path taken, sram_read stays 0.
REQ-045 rst=0 during READ_SRAM -> sram_read=0 asynchronously; a later sram_ready produces no cache write; state is IDLE after release.
REQ-046 Back-to-back load miss then load hit to the same block -> second access completes with zero wait.

Source files
------------

// File: rtl/cache_controller.sv
// Cache controller: sits between the pipeline memory stage, a set-associative
// cache and a 64-bit-block SRAM.
// Loads that hit complete in the same cycle. Load misses fetch one 64-bit block
// and write it into the cache as two words. Stores are write-through and
// no-allocate: a store hit invalidates the cached copy, then the word goes to SRAM.
//
// Handshakes:
//   pipeline: MEM_R_EN / MEM_W_EN are held until ready=1. The access completes
//             in the cycle where ready=1. Request changes while ready=0 are
//             ignored because address and data are latched on leaving IDLE.
//   sram:     sram_read / sram_write are held until a one-cycle sram_ready pulse.
//             sram_ready is ignored in any state that is not waiting for it.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [18:0] cache_address,
  output logic [31:0] cache_wdata,
  output logic        cache_w_en,
  output logic        invalidate,
  output logic        change_LRU,
  input  logic        hit_or_miss,
  input  logic [31:0] cache_rdata,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_SRAM  = 3'd1,
    FILL_LO    = 3'd2,
    FILL_HI    = 3'd3,
    WRITE_SRAM = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [63:0] block_q;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  assign state_dbg = state;

  // Live request in IDLE, latched request for the rest of a transaction.
  assign cur_addr   = (state == IDLE) ? address : addr_q;
  assign cur_wdata  = (state == IDLE) ? wdata   : wdata_q;
  assign sram_wdata = cur_wdata;

  // Transaction sequencing; latches the request when it leaves IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      block_q <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state   <= WRITE_SRAM;
            addr_q  <= address;
            wdata_q <= wdata;
          end else if (MEM_R_EN && !hit_or_miss) begin
            state  <= READ_SRAM;
            addr_q <= address;
          end
        end
        READ_SRAM: begin
          if (sram_ready) begin
            block_q <= sram_rdata;
            state   <= FILL_LO;
          end
        end
        FILL_LO:    state <= FILL_HI;
        FILL_HI:    state <= IDLE;
        WRITE_SRAM: if (sram_ready) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Strobes, addresses and completion decoded from state and inputs.
  // Reset forces every strobe low without waiting for a clock.
  always_comb begin
    ready         = 1'b0;
    rdata         = cache_rdata;
    cache_address = cur_addr[18:0];
    cache_wdata   = block_q[31:0];
    cache_w_en    = 1'b0;
    invalidate    = 1'b0;
    change_LRU    = 1'b0;
    sram_read     = 1'b0;
    sram_write    = 1'b0;
    sram_address  = {cur_addr[31:3], 3'b000};
    case (state)
      IDLE: begin
        if (MEM_W_EN) begin
          invalidate   = hit_or_miss;
          sram_address = cur_addr;
        end else if (MEM_R_EN) begin
          ready = hit_or_miss;
        end else begin
          ready = 1'b1;
        end
      end
      READ_SRAM: sram_read = 1'b1;
      FILL_LO: begin
        cache_w_en    = 1'b1;
        cache_address = {addr_q[18:3], 1'b0, addr_q[1:0]};
      end
      FILL_HI: begin
        cache_w_en    = 1'b1;
        cache_wdata   = block_q[63:32];
        change_LRU    = 1'b1;
        ready         = 1'b1;
        rdata         = addr_q[2] ? block_q[63:32] : block_q[31:0];
        cache_address = {addr_q[18:3], 1'b1, addr_q[1:0]};
      end
      WRITE_SRAM: begin
        sram_write   = 1'b1;
        sram_address = cur_addr;
        ready        = sram_ready;
      end
      default: ready = 1'b0;
    endcase
    if (!rst) begin
      sram_read  = 1'b0;
      sram_write = 1'b0;
      cache_w_en = 1'b0;
      invalidate = 1'b0;
      change_LRU = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: IDLE decode table, directed multi-cycle
// sequences, then random loads/stores against a transaction-level model.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic [31:0] address, wdata;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [18:0] cache_address;
  logic [31:0] cache_wdata;
  logic        cache_w_en, invalidate, change_LRU;
  logic        hit_or_miss;
  logic [31:0] cache_rdata;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_read, sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [2:0]  state_dbg;

  cache_controller dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_wdata(cache_wdata),
    .cache_w_en(cache_w_en), .invalidate(invalidate), .change_LRU(change_LRU),
    .hit_or_miss(hit_or_miss), .cache_rdata(cache_rdata),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- environment controls ----------------
  logic        use_man, hit_man, auto_sram, sram_ready_man, sram_ready_auto;
  logic [31:0] crd_man;
  logic [63:0] rd_man, rd_auto;

  // ---------------- cache model (direct array indexed by [18:3]) ----------------
  bit          cv [0:65535];
  logic [63:0] cd [0:65535];

  assign hit_or_miss = use_man ? hit_man : cv[cache_address[18:3]];
  assign cache_rdata = use_man ? crd_man :
                       (cache_address[2] ? cd[cache_address[18:3]][63:32]
                                         : cd[cache_address[18:3]][31:0]);

  always @(posedge clk) begin
    if (cache_w_en) begin
      if (cache_address[2]) cd[cache_address[18:3]][63:32] <= cache_wdata;
      else                  cd[cache_address[18:3]][31:0]  <= cache_wdata;
      if (change_LRU) cv[cache_address[18:3]] <= 1'b1;
    end
    if (invalidate) cv[cache_address[18:3]] <= 1'b0;
  end

  // ---------------- SRAM model ----------------
  logic [31:0] sram_mem [logic [29:0]];
  logic [64:0] act_q [$];   // {is_write, byte address, data}

  function automatic logic [31:0] dflt_word(input logic [29:0] wa);
    return {wa, 2'b00} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] sram_word(input logic [29:0] wa);
    if (sram_mem.exists(wa)) return sram_mem[wa];
    return dflt_word(wa);
  endfunction

  assign sram_ready = sram_ready_auto | sram_ready_man;
  assign sram_rdata = auto_sram ? rd_auto : rd_man;

  initial begin
    sram_ready_auto = 1'b0;
    rd_auto = 64'd0;
    forever begin
      @(negedge clk);
      if (auto_sram && (sram_read || sram_write)) begin
        int d;
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        if (sram_read) begin
          rd_auto = {sram_word(sram_address[31:2] + 30'd1), sram_word(sram_address[31:2])};
          act_q.push_back({1'b0, sram_address, 32'h0});
        end else begin
          sram_mem[sram_address[31:2]] = sram_wdata;
          act_q.push_back({1'b1, sram_address, sram_wdata});
        end
        sram_ready_auto = 1'b1;
        @(negedge clk);
        sram_ready_auto = 1'b0;
      end
    end
  end

  // ---------------- invariant monitor ----------------
  int mon_bad = 0;
  always @(negedge clk) begin
    if ((sram_read && sram_write) || (cache_w_en && invalidate)) mon_bad <= mon_bad + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [64:0] exp_q [$];
  logic [31:0] ref_mem [logic [29:0]];
  bit          ref_cached [logic [28:0]];

  function automatic logic [31:0] ref_word(input logic [29:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return dflt_word(wa);
  endfunction

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  // Drives one request (called at posedge+1), returns rdata and the cycle
  // index (0 = request cycle) in which ready was seen.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] got,
                           output int cyc, output bit ok);
    MEM_R_EN = rd; MEM_W_EN = wr; address = a; wdata = d;
    ok = 1'b0; cyc = 0; got = 32'h0;
    for (int i = 0; i < 40; i++) begin
      samp();
      if (ready) begin
        got = rdata; cyc = i; ok = 1'b1;
        break;
      end
    end
    tick();
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  // ---------------- IDLE decode table ----------------
  typedef struct {
    logic        rd, wr, hit;
    logic [31:0] addr, crd;
    logic        e_ready, e_inv, chk_rd;
    logic [31:0] e_rdata;
    logic [18:0] e_caddr;
  } vec_t;
  vec_t vecs [8];

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    int          cyc;
    bit          ok;
    logic [2:0]  idle_snap;
    int          exp_base;

    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = 32'h0; wdata = 32'h0;
    use_man = 1'b1; hit_man = 1'b0; crd_man = 32'h0; auto_sram = 1'b0;
    sram_ready_man = 1'b0; rd_man = 64'h0;

    vecs[0] = '{rd:0, wr:0, hit:0, addr:32'h0000_0104, crd:32'h0,         e_ready:1, e_inv:0, chk_rd:0, e_rdata:32'h0,         e_caddr:19'h00104};
    vecs[1] = '{rd:1, wr:0, hit:1, addr:32'h0000_0104, crd:32'hDEADBEEF,  e_ready:1, e_inv:0, chk_rd:1, e_rdata:32'hDEADBEEF,  e_caddr:19'h00104};
    vecs[2] = '{rd:1, wr:0, hit:0, addr:32'h0000_0104, crd:32'h55AA55AA,  e_ready:0, e_inv:0, chk_rd:0, e_rdata:32'h0,         e_caddr:19'h00104};
    vecs[3] = '{rd:0, wr:1, hit:1, addr:32'h0000_0200, crd:32'h0,         e_ready:0, e_inv:1, chk_rd:0, e_rdata:32'h0,         e_caddr:19'h00200};
    vecs[4] = '{rd:0, wr:1, hit:0, addr:32'h0000_0204, crd:32'h0,         e_ready:0, e_inv:0, chk_rd:0, e_rdata:32'h0,         e_caddr:19'h00204};
    vecs[5] = '{rd:1, wr:1, hit:1, addr:32'h0007_FFFC, crd:32'h0,         e_ready:0, e_inv:1, chk_rd:0, e_rdata:32'h0,         e_caddr:19'h7FFFC};
    vecs[6] = '{rd:1, wr:0, hit:1, addr:32'hFFFF_FFF8, crd:32'h12345678,  e_ready:1, e_inv:0, chk_rd:1, e_rdata:32'h12345678,  e_caddr:19'h7FFF8};
    vecs[7] = '{rd:0, wr:0, hit:1, addr:32'hABCD_E004, crd:32'h0,         e_ready:1, e_inv:0, chk_rd:0, e_rdata:32'h0,         e_caddr:19'h5E004};

    // Reset: strobes low, even with a store hit presented.
    #2;
    chk("reset_strobes", 65'({sram_read, sram_write, cache_w_en, invalidate, change_LRU}), 65'(0));
    MEM_W_EN = 1'b1; hit_man = 1'b1; #1;
    chk("reset_invalidate", 65'(invalidate), 65'(0));
    MEM_W_EN = 1'b0; hit_man = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #3;
    chk("after_reset_ready", 65'(ready), 65'(1));
    idle_snap = state_dbg;
    tick();

    // Same-cycle IDLE decode.
    for (int i = 0; i < 8; i++) begin
      MEM_R_EN = vecs[i].rd; MEM_W_EN = vecs[i].wr; hit_man = vecs[i].hit;
      crd_man = vecs[i].crd; address = vecs[i].addr;
      #3;
      chk($sformatf("vec%0d_ready", i), 65'(ready), 65'(vecs[i].e_ready));
      chk($sformatf("vec%0d_inval", i), 65'(invalidate), 65'(vecs[i].e_inv));
      chk($sformatf("vec%0d_strobes", i), 65'({sram_read, sram_write, cache_w_en, change_LRU}), 65'(0));
      chk($sformatf("vec%0d_caddr", i), 65'(cache_address), 65'(vecs[i].e_caddr));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 65'(rdata), 65'(vecs[i].e_rdata));
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      tick();
    end

    // Load miss at 0x104, sram_ready in the 4th cycle after the request.
    hit_man = 1'b0; MEM_R_EN = 1'b1; address = 32'h0000_0104;
    samp(); chk("miss_c0_ready", 65'(ready), 65'(0));
    tick(); samp();
    chk("miss_c1_sram_read", 65'(sram_read), 65'(1));
    chk("miss_c1_sram_addr", 65'(sram_address), 65'(32'h100));
    chk("miss_state_moved", 65'(state_dbg != idle_snap), 65'(1));
    tick(); MEM_R_EN = 1'b0; address = 32'h0000_03F0;   // request drops/changes: ignored
    tick(); samp();
    chk("miss_c3_sram_read", 65'(sram_read), 65'(1));
    chk("miss_c3_sram_addr", 65'(sram_address), 65'(32'h100));
    tick(); sram_ready_man = 1'b1; rd_man = 64'h11111111_22222222;
    samp(); chk("miss_c4_ready", 65'(ready), 65'(0));
    tick(); sram_ready_man = 1'b0;
    samp();
    chk("fill_lo_wen", 65'(cache_w_en), 65'(1));
    chk("fill_lo_wdata", 65'(cache_wdata), 65'(32'h22222222));
    chk("fill_lo_lru", 65'(change_LRU), 65'(0));
    chk("fill_lo_caddr", 65'(cache_address), 65'(19'h00100));
    chk("fill_lo_ready", 65'(ready), 65'(0));
    tick(); samp();
    chk("fill_hi_wen", 65'(cache_w_en), 65'(1));
    chk("fill_hi_wdata", 65'(cache_wdata), 65'(32'h11111111));
    chk("fill_hi_lru", 65'(change_LRU), 65'(1));
    chk("fill_hi_caddr", 65'(cache_address), 65'(19'h00104));
    chk("fill_hi_ready", 65'(ready), 65'(1));
    chk("fill_hi_rdata", 65'(rdata), 65'(32'h11111111));
    tick();

    // Back-to-back hit on the block just filled: zero wait.
    use_man = 1'b0; MEM_R_EN = 1'b1; address = 32'h0000_0100;
    samp();
    chk("b2b_hit_ready", 65'(ready), 65'(1));
    chk("b2b_hit_rdata", 65'(rdata), 65'(32'h22222222));
    chk("b2b_no_sram", 65'({sram_read, sram_write}), 65'(0));
    tick(); MEM_R_EN = 1'b0;

    // Store hit: one-cycle invalidate, SRAM write with latched address/data.
    use_man = 1'b1; hit_man = 1'b1; MEM_W_EN = 1'b1;
    address = 32'h0000_0200; wdata = 32'hA5A5A5A5;
    samp();
    chk("st_c0_inval", 65'(invalidate), 65'(1));
    chk("st_c0_ready", 65'(ready), 65'(0));
    tick(); address = 32'h0000_3000; wdata = 32'h0; hit_man = 1'b0;
    samp();
    chk("st_c1_inval", 65'(invalidate), 65'(0));
    chk("st_c1_sram_write", 65'(sram_write), 65'(1));
    chk("st_c1_sram_addr", 65'(sram_address), 65'(32'h200));
    chk("st_c1_sram_wdata", 65'(sram_wdata), 65'(32'hA5A5A5A5));
    chk("st_c1_ready", 65'(ready), 65'(0));
    tick(); sram_ready_man = 1'b1;
    samp();
    chk("st_done_ready", 65'(ready), 65'(1));
    chk("st_done_sram_write", 65'(sram_write), 65'(1));
    tick(); sram_ready_man = 1'b0; MEM_W_EN = 1'b0;
    samp(); chk("st_after_write", 65'(sram_write), 65'(0));
    tick();

    // Load and store together: store path, no SRAM read.
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; address = 32'h0000_0204; wdata = 32'h0BADF00D; hit_man = 1'b0;
    samp(); chk("both_c0_read", 65'(sram_read), 65'(0));
    tick(); samp();
    chk("both_c1_write", 65'(sram_write), 65'(1));
    chk("both_c1_read", 65'(sram_read), 65'(0));
    tick(); sram_ready_man = 1'b1;
    samp(); chk("both_done_ready", 65'(ready), 65'(1));
    tick(); sram_ready_man = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;

    // Reset in READ_SRAM, then a stray sram_ready.
    MEM_R_EN = 1'b1; address = 32'h0000_0108;
    tick();
    chk("rst_pre_read", 65'(sram_read), 65'(1));
    rst = 1'b0; #1;
    chk("rst_read_drop", 65'(sram_read), 65'(0));
    MEM_R_EN = 1'b0; #1;
    rst = 1'b1;
    samp();
    chk("rst_release_ready", 65'(ready), 65'(1));
    chk("rst_release_read", 65'(sram_read), 65'(0));
    tick(); sram_ready_man = 1'b1; rd_man = 64'hFEEDFACE_CAFEF00D;
    samp(); chk("stray_ready_idle", 65'(ready), 65'(1));
    tick(); sram_ready_man = 1'b0;
    samp();
    chk("stray_no_cache_write", 65'(cache_w_en), 65'(0));
    chk("stray_no_sram", 65'({sram_read, sram_write}), 65'(0));
    tick();

    // Random traffic against the transaction-level model.
    use_man = 1'b0; auto_sram = 1'b1; exp_base = 0;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, d, exp_rd;
      int kind, gap;
      logic rd, wr, hit;
      a    = 32'h052C_0000 | (32'($urandom_range(0, 15)) << 3) | (32'($urandom_range(0, 1)) << 2);
      d    = $urandom;
      kind = $urandom_range(0, 3);
      wr   = (kind == 0 || kind == 3);
      rd   = (kind != 0);
      hit  = ref_cached.exists(a[31:3]);
      exp_rd = ref_word(a[31:2]);
      if (wr) begin
        exp_q.push_back({1'b1, a, d});
        ref_mem[a[31:2]] = d;
        if (hit) ref_cached.delete(a[31:3]);
      end else if (!hit) begin
        exp_q.push_back({1'b0, a[31:3], 3'b000, 32'h0});
        ref_cached[a[31:3]] = 1'b1;
      end
      do_access(rd, wr, a, d, got, cyc, ok);
      chk("rnd_complete", 65'(ok), 65'(1));
      if (ok && !wr) begin
        chk("rnd_load_rdata", 65'(got), 65'(exp_rd));
        if (hit) chk("rnd_hit_zero_wait", 65'(cyc), 65'(0));
        else     chk("rnd_miss_latency", 65'(cyc >= 3), 65'(1));
      end
      if (ok && wr) chk("rnd_store_latency", 65'(cyc >= 1), 65'(1));
      for (int k = exp_base; k < exp_q.size(); k++)
        chk("rnd_sram_op", (k < act_q.size()) ? act_q[k] : {65{1'b1}}, exp_q[k]);
      chk("rnd_sram_op_count", 65'(act_q.size()), 65'(exp_q.size()));
      exp_base = exp_q.size();
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    chk("invariants", 65'(mon_bad), 65'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
